fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the five-stage RV32I pipeline. It owns the fetch PC and runs a single-outstanding valid/ready request/response handshake to instruction memory. It also buffers one returned instruction and drives the IF/ID pipeline register (instr_d, pc_d, pcplus4_d) that feeds the decode-stage control unit. It honours stall_f/stall_d/flush_d from the hazard unit and PC redirects (pcsrc_e/pctarget_e) from execute.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INSTR, 32'h0000_0013: bubble instruction (addi x0,x0,0) placed in instr_d when invalid.

Ports (clock and reset first):
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address; word aligned.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response data valid; never asserted in the same cycle as its accept.
- imem_rsp_data  in  32  returned instruction word.
- stall_f  in  1  hazard unit: do not start a new fetch.
- stall_d  in  1  hazard unit: hold the IF/ID register.
- flush_d  in  1  hazard unit: bubble the IF/ID register.
- pcsrc_e  in  1  redirect strobe: branch taken or jump.
- pctarget_e  in  32  redirect target.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pcplus4_d  out  32  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real instruction.

## Operation
- Registers: pc_f (next fetch address), state, drop flag, redir_pc, and a one-entry buffer (buf_valid, buf_instr, buf_pc).
- IDLE: imem_req_valid=0. Goes to REQ when stall_f=0 and buf_valid=0.
- REQ: imem_req_valid=1, imem_req_addr=pc_f. Valid and address are held stable until imem_req_ready. On accept: go to WAIT, req_pc<=pc_f, pc_f<=pc_f+4 (mod 2^32).
- WAIT: waits for imem_rsp_valid. No second request is issued while in WAIT.
- Response handling, not dropped:
  - If buf_valid=0 and stall_d=0, the word loads IF/ID directly.
  - Otherwise it goes to the buffer.
  - Next state is REQ if the word went directly to IF/ID and stall_f=0; otherwise IDLE.
- Response handling, dropped: the word is discarded, drop<=0, pc_f<=redir_pc, next state IDLE.
- IF/ID update at each edge with stall_d=0, in priority order:
  1. flush_d: valid_d<=0, instr_d<=NOP_INSTR.
  2. buf_valid: load from the buffer, buf_valid<=0.
  3. Direct response: load the response word.
  4. Otherwise: bubble.
- Loading IF/ID sets pc_d=fetch PC and pcplus4_d=pc_d+4.
- With stall_d=1, IF/ID holds, including while flush_d is high.
- Redirect (pcsrc_e=1), all in the same edge:
  - buf_valid<=0.
  - In IDLE: pc_f<=pctarget_e.
  - In REQ or WAIT: drop<=1, redir_pc<=pctarget_e. A request already in REQ still completes its handshake; its response is dropped.
  - A response arriving in the redirect cycle is dropped.
- A second redirect while drop=1 overwrites redir_pc; the last redirect wins.
- stall_f only gates new requests; an in-flight fetch always completes.

## Timing
- Reset values: state=IDLE, pc_f=RESET_PC, drop=0, buf_valid=0, imem_req_valid=0, imem_req_addr=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0, valid_d=0.
- Latency with zero-wait memory (ready in REQ, response one cycle later):
  - c0 accept.
  - c1 response; IF/ID is valid after the c1 edge.
  - The next REQ is in c2.
- Throughput: one instruction per 2 cycles.
- First request after reset: imem_req_valid rises in the 2nd cycle after rst deasserts (IDLE→REQ).
- Redirect to a new fetch:
  - Redirect in IDLE: request at the target starts 1 cycle later.
  - Redirect in WAIT: request starts 1 cycle after the dropped response (WAIT→IDLE→REQ).
- Reset asserted mid-handshake aborts immediately. The memory must discard any outstanding response.

## Test plan
- Reset, zero-wait memory returning 0x00A00093 at 0x0 and 0x00100113 at 0x4:
  - imem_req_addr sequences 0x0, 0x4.
  - pc_d=0x0/pcplus4_d=0x4 with valid_d=1, then pc_d=0x4.
- Memory holds imem_req_ready=0 for 3 cycles:
  - imem_req_valid stays 1.
  - imem_req_addr stays 0x8.
  - pc_f advances only after accept.
- stall_d=1 for 4 cycles while a response arrives:
  - The word lands in the buffer and no new request is issued.
  - IF/ID is unchanged until stall_d drops, then loads the buffered word.
- pcsrc_e=1 with pctarget_e=0x100 while in WAIT:
  - The pending response (addr 0xC) never appears in IF/ID.
  - The next imem_req_addr is 0x100.
- flush_d=1 with stall_d=0: the next edge gives valid_d=0, instr_d=0x00000013. With stall_d=1 and flush_d=1, IF/ID holds.
- Assert rst while in WAIT: all outputs return to reset values asynchronously. Refetch starts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response channel between fetch and imem
interface fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: single-outstanding imem fetch, one-entry buffer, IF/ID register
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master mem,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pcsrc_e,
  input  logic [31:0] pctarget_e,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_n;
  logic [31:0] pc_f;
  logic [31:0] req_pc;
  logic        drop;
  logic [31:0] redir_pc;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic accept;
  logic rsp_fire;
  logic rsp_drop;
  logic rsp_keep;
  logic rsp_direct;

  assign accept     = (state == REQ) && mem.imem_req_ready;
  assign rsp_fire   = (state == WAIT) && mem.imem_rsp_valid;
  // A response landing in the redirect cycle belongs to the wrong path too
  assign rsp_drop   = rsp_fire && (drop || pcsrc_e);
  assign rsp_keep   = rsp_fire && !rsp_drop;
  assign rsp_direct = rsp_keep && !buf_valid && !stall_d;

  assign mem.imem_req_addr = pc_f;

  always_comb begin
    state_n            = state;
    mem.imem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!stall_f && !buf_valid) state_n = REQ;
      end
      REQ: begin
        mem.imem_req_valid = 1'b1;
        if (mem.imem_req_ready) state_n = WAIT;
      end
      WAIT: begin
        if (rsp_drop) state_n = IDLE;
        else if (rsp_keep) state_n = (rsp_direct && !stall_f) ? REQ : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f     <= RESET_PC;
      req_pc   <= RESET_PC;
      drop     <= 1'b0;
      redir_pc <= RESET_PC;
    end else begin
      if ((state == IDLE) && pcsrc_e) pc_f <= pctarget_e;
      else if (accept)                pc_f <= pc_f + 32'd4;
      else if (rsp_drop)              pc_f <= pcsrc_e ? pctarget_e : redir_pc;

      if (accept) req_pc <= pc_f;

      // An in-flight fetch cannot be cancelled, so remember where to resume
      if (pcsrc_e && ((state == REQ) || ((state == WAIT) && !rsp_fire))) drop <= 1'b1;
      else if (rsp_drop)                                                drop <= 1'b0;

      if (pcsrc_e && (state != IDLE)) redir_pc <= pctarget_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_instr <= NOP_INSTR;
      buf_pc    <= RESET_PC;
    end else if (pcsrc_e) begin
      buf_valid <= 1'b0;
    end else if (rsp_keep && !rsp_direct) begin
      buf_valid <= 1'b1;
      buf_instr <= mem.imem_rsp_data;
      buf_pc    <= req_pc;
    end else if (!stall_d && !flush_d && buf_valid) begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d   <= NOP_INSTR;
      pc_d      <= 32'h0;
      pcplus4_d <= 32'h0;
      valid_d   <= 1'b0;
    end else if (!stall_d) begin
      if (flush_d) begin
        valid_d <= 1'b0;
        instr_d <= NOP_INSTR;
      end else if (buf_valid) begin
        valid_d   <= 1'b1;
        instr_d   <= buf_instr;
        pc_d      <= buf_pc;
        pcplus4_d <= buf_pc + 32'd4;
      end else if (rsp_direct) begin
        valid_d   <= 1'b1;
        instr_d   <= mem.imem_rsp_data;
        pc_d      <= req_pc;
        pcplus4_d <= req_pc + 32'd4;
      end else begin
        valid_d <= 1'b0;
        instr_d <= NOP_INSTR;
      end
    end
  end

endmodule
